// File: rtl/match_controller_pkg.sv
// Shared types for the fencing match controller: FSM states, winner codes
// and the common video data/location types.
package match_controller_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    COUNTDOWN    = 3'd1,
    FIGHT        = 3'd2,
    PAUSE        = 3'd3,
    SUDDEN_DEATH = 3'd4,
    DONE         = 3'd5
  } match_state_t;

  typedef enum logic [1:0] {
    WIN_NONE     = 2'b00,
    WIN_PLAYER   = 2'b01,
    WIN_OPPONENT = 2'b10
  } winner_t;

  typedef logic [7:0] data_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } location_t;

  localparam int FRAME_CNT_W = 14;

endpackage

// File: rtl/match_controller_frame_counter.sv
// Loadable frame down-counter: decrements once per tick and stops at zero.
module frame_counter #(
  parameter int              W       = 14,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         load_in,
  input  logic [W-1:0] load_val_in,
  input  logic         tick_in,
  output logic [W-1:0] count_out,
  output logic         zero_out
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_count <= RST_VAL;
    end else if (load_in) begin
      r_count <= load_val_in;
    end else if (tick_in && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign count_out = r_count;
  assign zero_out  = (r_count == '0);

endmodule

// File: rtl/match_controller.sv
// Bout sequencing for the fencing game: countdown, fight, post-touch pauses,
// bout clock expiry, sudden death and winner selection.
module match_controller
  import match_controller_pkg::*;
#(
  parameter int WIN_SCORE        = 5,
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int PAUSE_FRAMES     = 120,
  parameter int BOUT_FRAMES      = 10800
) (
  input  logic         clk_pixel_in,
  input  logic         rst_in,
  input  logic         frame_tick_in,
  input  logic         start_in,
  input  logic         touch_valid_in,
  input  logic         player_touch_in,
  input  logic         opponent_touch_in,
  output logic         fight_enable_out,
  output logic         action_clear_out,
  output logic [3:0]   player_score_out,
  output logic [3:0]   opponent_score_out,
  output match_state_t state_out,
  output logic [13:0]  frames_left_out,
  output logic [1:0]   winner_out
);

  localparam logic [3:0]             WIN       = 4'(WIN_SCORE);
  localparam logic [FRAME_CNT_W-1:0] CD_LEN    = FRAME_CNT_W'(COUNTDOWN_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] PAUSE_LEN = FRAME_CNT_W'(PAUSE_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] BOUT_LEN  = FRAME_CNT_W'(BOUT_FRAMES);

  match_state_t r_state, w_next;
  winner_t      r_winner, w_winner;
  logic [3:0]   r_ps, r_os, w_ps, w_os;
  logic         r_sd, w_sd, r_fight_en, r_clear, w_clear;

  logic                   w_ph_load, w_ph_tick, w_ph_zero;
  logic [FRAME_CNT_W-1:0] w_ph_val, w_ph_count;
  logic                   w_bout_load, w_bout_tick, w_bout_zero;
  logic [FRAME_CNT_W-1:0] w_bout_count;
  logic                   w_touch, w_double, w_ph_done, w_expire;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= WIN) ? s : s + 4'd1;
  endfunction

  frame_counter #(.W(FRAME_CNT_W), .RST_VAL('0)) u_phase (
    .clk_in      (clk_pixel_in),
    .rst_in      (rst_in),
    .load_in     (w_ph_load),
    .load_val_in (w_ph_val),
    .tick_in     (w_ph_tick),
    .count_out   (w_ph_count),
    .zero_out    (w_ph_zero)
  );

  frame_counter #(.W(FRAME_CNT_W), .RST_VAL(BOUT_LEN)) u_bout (
    .clk_in      (clk_pixel_in),
    .rst_in      (rst_in),
    .load_in     (w_bout_load),
    .load_val_in (BOUT_LEN),
    .tick_in     (w_bout_tick),
    .count_out   (w_bout_count),
    .zero_out    (w_bout_zero)
  );

  assign w_touch   = touch_valid_in && (player_touch_in || opponent_touch_in);
  assign w_double  = player_touch_in && opponent_touch_in;
  assign w_ph_done = frame_tick_in && (w_ph_zero || (w_ph_count == FRAME_CNT_W'(1)));
  assign w_expire  = frame_tick_in && (w_bout_zero || (w_bout_count == FRAME_CNT_W'(1)));

  always_comb begin
    w_next      = r_state;
    w_ps        = r_ps;
    w_os        = r_os;
    w_winner    = r_winner;
    w_sd        = r_sd;
    w_clear     = 1'b0;
    w_ph_load   = 1'b0;
    w_ph_val    = '0;
    w_ph_tick   = 1'b0;
    w_bout_load = 1'b0;
    w_bout_tick = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start_in) begin
          w_next      = COUNTDOWN;
          w_ps        = '0;
          w_os        = '0;
          w_winner    = WIN_NONE;
          w_sd        = 1'b0;
          w_bout_load = 1'b1;
          w_ph_load   = 1'b1;
          w_ph_val    = CD_LEN;
        end
      end
      COUNTDOWN, PAUSE: begin
        w_ph_tick = frame_tick_in;
        if (w_ph_done) begin
          w_next  = r_sd ? SUDDEN_DEATH : FIGHT;
          w_clear = 1'b1;
        end
      end
      FIGHT: begin
        w_bout_tick = frame_tick_in;
        if (w_touch) begin
          w_next    = PAUSE;
          w_ph_load = 1'b1;
          w_ph_val  = PAUSE_LEN;
          if (w_double) begin
            // A double touch cannot decide the bout, so it is annulled at match point
            if ((r_ps != WIN - 4'd1) && (r_os != WIN - 4'd1)) begin
              w_ps = sat_inc(r_ps);
              w_os = sat_inc(r_os);
            end
          end else if (player_touch_in) begin
            w_ps = sat_inc(r_ps);
            if (w_ps == WIN) begin
              w_next   = DONE;
              w_winner = WIN_PLAYER;
            end
          end else begin
            w_os = sat_inc(r_os);
            if (w_os == WIN) begin
              w_next   = DONE;
              w_winner = WIN_OPPONENT;
            end
          end
        end
        // Expiry is judged on the scores after any same-cycle touch
        if (w_expire && (w_next != DONE)) begin
          if (w_ps > w_os) begin
            w_next   = DONE;
            w_winner = WIN_PLAYER;
          end else if (w_os > w_ps) begin
            w_next   = DONE;
            w_winner = WIN_OPPONENT;
          end else begin
            w_sd      = 1'b1;
            w_next    = PAUSE;
            w_ph_load = 1'b1;
            w_ph_val  = PAUSE_LEN;
          end
        end
      end
      SUDDEN_DEATH: begin
        if (w_touch) begin
          if (w_double) begin
            w_next    = PAUSE;
            w_ph_load = 1'b1;
            w_ph_val  = PAUSE_LEN;
          end else if (player_touch_in) begin
            w_ps     = sat_inc(r_ps);
            w_next   = DONE;
            w_winner = WIN_PLAYER;
          end else begin
            w_os     = sat_inc(r_os);
            w_next   = DONE;
            w_winner = WIN_OPPONENT;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel_in) begin
    if (!rst_in) begin
      r_state    <= IDLE;
      r_ps       <= '0;
      r_os       <= '0;
      r_winner   <= WIN_NONE;
      r_sd       <= 1'b0;
      r_fight_en <= 1'b0;
      r_clear    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_ps       <= w_ps;
      r_os       <= w_os;
      r_winner   <= w_winner;
      r_sd       <= w_sd;
      r_fight_en <= (w_next == FIGHT) || (w_next == SUDDEN_DEATH);
      r_clear    <= w_clear;
    end
  end

  assign state_out          = r_state;
  assign player_score_out   = r_ps;
  assign opponent_score_out = r_os;
  assign winner_out         = r_winner;
  assign fight_enable_out   = r_fight_en;
  assign action_clear_out   = r_clear;
  assign frames_left_out    = w_bout_count;

endmodule

// File: doc/match_controller.md
MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 The block SHALL have parameter WIN_SCORE, default 5, meaning touches needed to win (1..15).
REQ-002 The block SHALL have parameter COUNTDOWN_FRAMES, default 180, meaning the pre-bout countdown length in frames.
REQ-003 The block SHALL have parameter PAUSE_FRAMES, default 120, meaning the post-touch halt length in frames.
REQ-004 The block SHALL have parameter BOUT_FRAMES, default 10800, meaning the bout clock length in frames (3 min at 60 Hz).
REQ-005 The block SHALL have these ports: clk_pixel_in  input  1  pixel clock, the only clock.
REQ-006 The block SHALL have these ports: rst_in  input  1  synchronous, active-low reset.
REQ-007 The block SHALL have these ports: frame_tick_in  input  1  one-cycle pulse per video frame.
REQ-008 The block SHALL have these ports: start_in  input  1  one-cycle pulse from the decoded IR start code.
REQ-009 The block SHALL have these ports: touch_valid_in  input  1  qualifies the touch flags for one cycle.
REQ-010 The block SHALL have these ports: player_touch_in  input  1  player landed a touch on opponent.
REQ-011 The block SHALL have these ports: opponent_touch_in  input  1  opponent landed a touch on player.
REQ-012 The block SHALL have these ports: fight_enable_out  output  1  action FSM may accept block/lunge.
REQ-013 The block SHALL have these ports: action_clear_out  output  1  one-cycle pulse resetting action FSM state.
REQ-014 The block SHALL have these ports: player_score_out, opponent_score_out  output  4  current scores.
REQ-015 The block SHALL have these ports: state_out  output  match_state_t  current state.
REQ-016 The block SHALL have these ports: frames_left_out  output  14  bout-clock frames remaining.
REQ-017 The block SHALL have these ports: winner_out  output  2  00 none, 01 player, 10 opponent.

Function
REQ-018 The block SHALL implement states IDLE, COUNTDOWN, FIGHT, PAUSE, SUDDEN_DEATH and DONE.
REQ-019 In IDLE, start_in SHALL go to COUNTDOWN; clear scores and winner; load frames_left with BOUT_FRAMES; load the phase counter with COUNTDOWN_FRAMES.
REQ-020 In COUNTDOWN and PAUSE, each frame_tick_in SHALL decrement the phase counter.
REQ-021 On the tick that takes the phase counter to 0, the block SHALL enter FIGHT, or SUDDEN_DEATH if the sudden-death flag is set, and pulse action_clear_out in that same cycle.
REQ-022 fight_enable_out SHALL be 1 only in FIGHT and SUDDEN_DEATH, registered, and asserted in the first cycle of each of those states.
REQ-023 In FIGHT, each frame_tick_in SHALL decrement frames_left; frames_left SHALL hold in every other state.
REQ-024 A touch SHALL be counted only when touch_valid_in=1 in FIGHT/SUDDEN_DEATH; touches in other states SHALL be ignored.
REQ-025 On a single touch in FIGHT, the block SHALL increment that side's score; if it reaches WIN_SCORE go to DONE with the winner set, otherwise go to PAUSE with the phase counter=PAUSE_FRAMES.
REQ-026 On a double touch (both flags 1) in FIGHT, the block SHALL increment both scores unless either score equals WIN_SCORE-1, in which case the touch is annulled (no score change); it SHALL go to PAUSE in both cases.
REQ-027 If a touch and the frame_tick_in that takes frames_left 1->0 occur in the same cycle, the touch SHALL be processed first and the expiry evaluated on the updated scores.
REQ-028 On expiry (frames_left reaches 0 in FIGHT), the higher score SHALL win and the block go to DONE; on equal scores it SHALL set the sudden-death flag and go to PAUSE.
REQ-029 In SUDDEN_DEATH, a single touch SHALL score and win (DONE); a double touch SHALL be annulled and go to PAUSE.
REQ-030 Scores SHALL never exceed WIN_SCORE and never wrap.
REQ-031 In DONE, outputs SHALL hold; start_in SHALL restart as from IDLE.
REQ-032 start_in outside IDLE/DONE SHALL be ignored.
REQ-033 All outputs SHALL be registered; the state change occurs 1 cycle after the triggering input.

Reset
REQ-034 When rst_in=0 at a clock edge, the block SHALL enter IDLE with scores=0, winner_out=00, frames_left_out=BOUT_FRAMES, fight_enable_out=0, action_clear_out=0, phase counter=0, sudden-death flag=0, regardless of state (mid-bout included).
REQ-035 Reset SHALL take priority over start_in, touch and tick in the same cycle.

Structure
REQ-036 match_state_t and the winner encoding SHALL live in the shared package alongside data_t/location_t.
REQ-037 The frame-count down-counter (load, decrement on tick, zero flag) SHALL be one sub-module, frame_counter, instantiated twice (phase counter and bout clock).

Verification
REQ-038 Bench SHALL check: reset, then start_in, then 180 ticks -> FIGHT, action_clear_out pulses once, fight_enable_out=1.
REQ-039 Bench SHALL check: in FIGHT, 5 player-only touches with 120-tick pauses between them -> player_score_out=5, winner_out=01, DONE, fight_enable_out=0.
REQ-040 Bench SHALL check: scores 4-4, double touch -> scores stay 4-4, PAUSE; scores 2-3, double touch -> 3-4.
REQ-041 Bench SHALL check: BOUT_FRAMES=10 at 1-1, 10 ticks -> PAUSE then SUDDEN_DEATH; opponent touch -> 1-2, winner_out=10.
REQ-042 Bench SHALL check: touch on the same cycle as the final tick at player 2-2 -> 3-2, winner_out=01.
REQ-043 Bench SHALL check: rst_in=0 during PAUSE at 3-1 -> next cycle IDLE, scores 0-0; touches and ticks in IDLE change nothing.
